// File: rtl/gpf_pkg.sv
// Shared types and helpers for the config readback transmitter.
package gpf_pkg;

    localparam int unsigned CFG_W_DEFAULT = 32;
    // Widest word odd_parity() accepts; narrower words are zero-extended.
    localparam int unsigned PARITY_MAX_W  = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } tx_state_e;

    // Bit that makes the XOR over word plus this bit equal to 1.
    function automatic logic odd_parity(input logic [PARITY_MAX_W-1:0] word);
        return ~(^word);
    endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period tick generator for the serial clock; cleared whenever disabled.
module spi_clkdiv #(
    parameter int unsigned DIV = 4
) (
    input  logic Clk_i,
    input  logic Rst_ni,
    input  logic En_i,
    output logic Half_tick_c
);

    localparam int unsigned CW = $clog2(DIV + 1);

    logic [CW-1:0] cnt_q;

    assign Half_tick_c = En_i && (cnt_q == CW'(DIV - 1));

    // Count DIV cycles per half period while enabled.
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            cnt_q <= '0;
        end else if (!En_i || Half_tick_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/cfg_readback_tx.sv
// Config word readback serializer (SPI mode 0, MSB first, Sck_o derived from Clk_i).
// Optional build macro GPF_TX_PARITY_EN appends an odd-parity bit after the LSB.
module cfg_readback_tx
    import gpf_pkg::*;
#(
    parameter int unsigned CFG_W = CFG_W_DEFAULT,
    parameter int unsigned DIV   = 4
) (
    input  logic             Clk_i,
    input  logic             Rst_ni,
    input  logic             Start_i,
    input  logic             Abort_i,
    input  logic [CFG_W-1:0] Data_i,
    output logic             Busy_o,
    output logic             Done_o,
    output logic             Cs_no,
    output logic             Sck_o,
    output logic             Sdo_o
);

`ifdef GPF_TX_PARITY_EN
    localparam int unsigned NB = CFG_W + 1;
`else
    localparam int unsigned NB = CFG_W;
`endif
    localparam int unsigned BCW = $clog2(NB + 1);

    tx_state_e         state_q, state_d;
    logic [NB-1:0]     shreg_q, shreg_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic              sck_q, sck_d;
    logic              sdo_q, sdo_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NB-1:0]     frame_c;
    logic              half_tick_c;
    logic              div_en_c;

    // Frame as shifted out: the word, plus its parity bit when enabled.
`ifdef GPF_TX_PARITY_EN
    assign frame_c = {Data_i, odd_parity(PARITY_MAX_W'(Data_i))};
`else
    assign frame_c = Data_i;
`endif

    assign div_en_c = (state_q != IDLE);

    spi_clkdiv #(
        .DIV (DIV)
    ) u_clkdiv (
        .Clk_i       (Clk_i),
        .Rst_ni      (Rst_ni),
        .En_i        (div_en_c),
        .Half_tick_c (half_tick_c)
    );

    // Next-state and next-output logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        sck_d     = sck_q;
        sdo_d     = sdo_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start_i && !Abort_i) begin
                    state_d   = LEAD;
                    shreg_d   = frame_c;
                    sdo_d     = frame_c[NB-1];
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            LEAD: begin
                if (half_tick_c) begin
                    state_d   = SHIFT;
                    sck_d     = 1'b1;
                    bit_cnt_d = BCW'(1);
                end
            end
            SHIFT: begin
                // The last bit keeps its low half here before the TRAIL guard.
                if (half_tick_c) begin
                    if (sck_q) begin
                        sck_d = 1'b0;
                        if (bit_cnt_q != BCW'(NB)) begin
                            shreg_d = shreg_q << 1;
                            sdo_d   = shreg_d[NB-1];
                        end
                    end else if (bit_cnt_q == BCW'(NB)) begin
                        state_d = TRAIL;
                    end else begin
                        sck_d     = 1'b1;
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            TRAIL: begin
                if (half_tick_c) begin
                    state_d   = IDLE;
                    cs_n_d    = 1'b1;
                    sdo_d     = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (Abort_i && (state_q != IDLE)) begin
            state_d   = IDLE;
            cs_n_d    = 1'b1;
            sck_d     = 1'b0;
            sdo_d     = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            bit_cnt_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sck_q     <= 1'b0;
            sdo_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            sck_q     <= sck_d;
            sdo_q     <= sdo_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Busy_o = busy_q;
    assign Done_o = done_q;
    assign Cs_no  = cs_n_q;
    assign Sck_o  = sck_q;
    assign Sdo_o  = sdo_q;

endmodule

// File: tb/tb_cfg_readback_tx.sv
// Scoreboard bench for cfg_readback_tx (CFG_W=8; DIV=2 main instance, DIV=1 reset instance).
module tb_cfg_readback_tx;

    localparam int unsigned CFG_W = 8;
`ifdef GPF_TX_PARITY_EN
    localparam int NB_EXP = 9;
    localparam int LAT2   = 40;
    localparam int LAT1   = 20;
`else
    localparam int NB_EXP = 8;
    localparam int LAT2   = 36;
    localparam int LAT1   = 18;
`endif

    logic             clk;
    logic             rst_n, rst_n1;
    logic             start, abort, start1, abort1;
    logic [CFG_W-1:0] data, data1;
    logic             busy, done, cs_n, sck, sdo;
    logic             busy1, done1, cs_n1, sck1, sdo1;

    cfg_readback_tx #(.CFG_W(CFG_W), .DIV(2)) u_dut (
        .Clk_i   (clk),
        .Rst_ni  (rst_n),
        .Start_i (start),
        .Abort_i (abort),
        .Data_i  (data),
        .Busy_o  (busy),
        .Done_o  (done),
        .Cs_no   (cs_n),
        .Sck_o   (sck),
        .Sdo_o   (sdo)
    );

    cfg_readback_tx #(.CFG_W(CFG_W), .DIV(1)) u_dut1 (
        .Clk_i   (clk),
        .Rst_ni  (rst_n1),
        .Start_i (start1),
        .Abort_i (abort1),
        .Data_i  (data1),
        .Busy_o  (busy1),
        .Done_o  (done1),
        .Cs_no   (cs_n1),
        .Sck_o   (sck1),
        .Sdo_o   (sdo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] frame;
        int         nbits;
        logic       done;
        int         lat;
        int         gap;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   stray_done = 0;
    int   idle_err   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [8:0] frame_of(input logic [7:0] d);
`ifdef GPF_TX_PARITY_EN
        return {d, ~(^d)};
`else
        return {1'b0, d};
`endif
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic dn, input int nbits,
                            input int lat, input int gap);
        exp_t e;
        e.frame = frame_of(d) >> (NB_EXP - nbits);
        e.nbits = nbits;
        e.done  = dn;
        e.lat   = lat;
        e.gap   = gap;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] d);
        data  = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            tick();
        end
        check("frame_timeout", 32'(busy), 32'd0);
        repeat (3) tick();
    endtask

    // Monitor: reconstruct each frame on the wire and compare against the queue.
    logic       cs_prev = 1'b1;
    logic       sck_prev = 1'b0;
    logic       in_frame = 1'b0;
    logic       prot_err = 1'b0;
    logic [8:0] cap = '0;
    int         nbit = 0, cyc = 0, gap_cnt = 0, gap_last = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            cs_prev  = 1'b1;
            sck_prev = 1'b0;
            in_frame = 1'b0;
        end else begin
            if (in_frame) cyc++;
            if (!cs_n && cs_prev) begin
                in_frame = 1'b1;
                cyc      = 0;
                nbit     = 0;
                cap      = '0;
                prot_err = 1'b0;
                gap_last = gap_cnt;
            end
            if (in_frame && !cs_n) begin
                if (busy !== 1'b1 || done !== 1'b0) prot_err = 1'b1;
                if (sck && !sck_prev) begin
                    cap = {cap[7:0], sdo};
                    nbit++;
                end
            end
            if (cs_n && (sck !== 1'b0 || sdo !== 1'b0 || busy !== 1'b0)) idle_err++;
            if (done && !(cs_n && !cs_prev)) stray_done++;
            if (cs_n && !cs_prev) begin
                gap_cnt = 1;
                if (in_frame) begin
                    if (sb_q.size() == 0) begin
                        check("frame_expected", 32'd0, 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        check("done_at_cs_rise", 32'(done), 32'(e.done));
                        check("bit_count", 32'(nbit), 32'(e.nbits));
                        check("frame_bits", 32'(cap), 32'(e.frame));
                        if (e.lat != 0) check("latency", 32'(cyc), 32'(e.lat));
                        if (e.gap != 0) check("cs_gap", 32'(gap_last), 32'(e.gap));
                        check("busy_cs_protocol", 32'(prot_err), 32'd0);
                    end
                    in_frame = 1'b0;
                end
            end else if (cs_n) begin
                gap_cnt++;
            end
            cs_prev  = cs_n;
            sck_prev = sck;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       sp;
        logic [8:0] cap1;
        int         rises, lowc, c1, nb1;

        rst_n = 1'b0; rst_n1 = 1'b0;
        start = 1'b0; abort = 1'b0; data = '0;
        start1 = 1'b0; abort1 = 1'b0; data1 = '0;

        // Reset held while Start toggles.
        repeat (3) begin
            tick();
            start  = ~start;
            start1 = ~start1;
            data   = 8'hFF;
            data1  = 8'hFF;
        end
        tick();
        check("reset_outputs", 32'({busy, done, cs_n, sck, sdo}), 32'h04);
        check("reset_outputs_div1", 32'({busy1, done1, cs_n1, sck1, sdo1}), 32'h04);
        start = 1'b0; start1 = 1'b0;
        tick();
        rst_n = 1'b1; rst_n1 = 1'b1;
        repeat (2) tick();

        // Single frames incl. all-zero/all-one and parity vectors.
        push_exp(8'hA5, 1'b1, NB_EXP, LAT2, 0); pulse_start(8'hA5); wait_idle();
        push_exp(8'h03, 1'b1, NB_EXP, LAT2, 0); pulse_start(8'h03); wait_idle();
        push_exp(8'h07, 1'b1, NB_EXP, LAT2, 0); pulse_start(8'h07); wait_idle();
        push_exp(8'hFF, 1'b1, NB_EXP, LAT2, 0); pulse_start(8'hFF); wait_idle();
        push_exp(8'h00, 1'b1, NB_EXP, LAT2, 0); pulse_start(8'h00); wait_idle();

        // Start pulse and Data change mid-frame are ignored.
        push_exp(8'h5A, 1'b1, NB_EXP, LAT2, 0);
        pulse_start(8'h5A);
        repeat (10) tick();
        data = 8'h0F; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        repeat (4) tick();

        // Start held: back-to-back frames with one idle Cs cycle.
        push_exp(8'h81, 1'b1, NB_EXP, LAT2, 0);
        push_exp(8'hC7, 1'b1, NB_EXP, LAT2, 1);
        data = 8'h81; start = 1'b1;
        tick();
        repeat (5) tick();
        data = 8'hC7;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done) break;
        end
        check("held_done_seen", 32'(done), 32'd1);
        tick();
        start = 1'b0;
        check("held_rearm_busy", 32'(busy), 32'd1);
        wait_idle();

        // Abort at the third Sck rise.
        push_exp(8'h96, 1'b0, 3, 0, 0);
        pulse_start(8'h96);
        rises = 0;
        for (int i = 0; i < 200 && rises < 3; i++) begin
            sp = sck;
            tick();
            if (sck && !sp) rises++;
        end
        check("abort_rises_seen", 32'(rises), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outputs", 32'({busy, done, cs_n, sck, sdo}), 32'h04);
        repeat (6) tick();

        // Abort and Start together in IDLE: nothing starts.
        data = 8'h3C; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        lowc = 0;
        repeat (8) begin
            tick();
            if (!cs_n || busy) lowc++;
        end
        check("abort_beats_start", 32'(lowc), 32'd0);

        // DIV=1: async reset mid-SHIFT, then a clean frame.
        data1 = 8'h3C; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        rises = 0;
        for (int i = 0; i < 50 && rises < 2; i++) begin
            sp = sck1;
            tick();
            if (sck1 && !sp) rises++;
        end
        check("div1_mid_frame_busy", 32'(busy1), 32'd1);
        @(posedge clk);
        #2 rst_n1 = 1'b0;
        #1;
        check("div1_async_reset", 32'({busy1, done1, cs_n1, sck1, sdo1}), 32'h04);
        @(posedge clk);
        #1 rst_n1 = 1'b1;
        tick();
        data1 = 8'hC3; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cap1 = '0; nb1 = 0; c1 = 0; sp = sck1;
        for (int i = 0; i < 100; i++) begin
            tick();
            c1++;
            if (sck1 && !sp) begin
                cap1 = {cap1[7:0], sdo1};
                nb1++;
            end
            sp = sck1;
            if (done1) break;
        end
        check("div1_done", 32'(done1), 32'd1);
        check("div1_latency", 32'(c1), 32'(LAT1));
        check("div1_bit_count", 32'(nb1), 32'(NB_EXP));
        check("div1_frame_bits", 32'(cap1), 32'(frame_of(8'hC3)));
        check("div1_cs_at_done", 32'(cs_n1), 32'd1);

        // Drain and global protocol counters.
        for (int i = 0; i < 200; i++) begin
            if (sb_q.size() == 0) break;
            tick();
        end
        repeat (3) tick();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("stray_done", 32'(stray_done), 32'd0);
        check("idle_protocol", 32'(idle_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
